// File: rtl/sram_axi_bridge_pkg.sv
// Shared encodings and AXI constants for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4,
        DONE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        INST_RD = 2'd0,
        DATA_RD = 2'd1,
        DATA_WR = 2'd2
    } kind_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    localparam logic [3:0] ID_INST_DEF    = 4'd0;
    localparam logic [3:0] ID_DATA_DEF    = 4'd1;

endpackage

// File: rtl/sram_axi_bridge.sv
// Single-outstanding AXI master: turns one SRAM-style inst/data request at a
// time into a single-beat AXI transaction and returns a one-cycle ok pulse.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter logic [3:0] ID_INST = ID_INST_DEF,
    parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic        inst_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_ren,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_read_ok,
    output logic        data_write_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    // Narrowest legal AXI size covering the enabled byte lanes.
    function automatic logic [2:0] awsize_of(input logic [3:0] wen);
        unique case (wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize_of = 3'd0;
            4'b0011, 4'b1100:                   awsize_of = 3'd1;
            default:                            awsize_of = AXI_SIZE_WORD;
        endcase
    endfunction

    state_e      state_q, state_d;
    kind_e       kind_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done_q, w_done_q;
    logic [31:0] inst_rdata_q, data_rdata_q;

    logic aw_hs, w_hs, r_hs;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign r_hs  = rvalid & rready;

    // Single-beat transfers: ids, responses and rlast carry nothing we act on.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, rid, rresp, rlast, bid, bresp};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (data_wen != 4'b0)          state_d = AW_W;
                else if (data_ren || inst_ren) state_d = AR;
            end
            AR:   if (arready) state_d = R;
            R:    if (rvalid)  state_d = DONE;
            AW_W: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = B;
            B:    if (bvalid)  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        inst_ok       = 1'b0;
        data_read_ok  = 1'b0;
        data_write_ok = 1'b0;
        unique case (state_q)
            AR:   arvalid = 1'b1;
            R:    rready  = 1'b1;
            AW_W: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
            end
            B:    bready  = 1'b1;
            DONE: begin
                inst_ok       = (kind_q == INST_RD);
                data_read_ok  = (kind_q == DATA_RD);
                data_write_ok = (kind_q == DATA_WR);
            end
            default: ;
        endcase
    end

    // Request capture only happens in IDLE, so pulses during a transfer are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_q       <= INST_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (state_q == IDLE) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                if (data_wen != 4'b0) begin
                    kind_q  <= DATA_WR;
                    addr_q  <= data_addr;
                    wdata_q <= data_wdata;
                    wstrb_q <= data_wen;
                end else if (data_ren) begin
                    kind_q <= DATA_RD;
                    addr_q <= data_addr;
                end else if (inst_ren) begin
                    kind_q <= INST_RD;
                    addr_q <= inst_addr;
                end
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (r_hs) begin
                if (kind_q == INST_RD) inst_rdata_q <= rdata;
                else                   data_rdata_q <= rdata;
            end
        end
    end

    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

    assign arid    = (kind_q == INST_RD) ? ID_INST : ID_DATA;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b0;
    assign arcache = 4'b0;
    assign arprot  = 3'b0;

    assign awid    = ID_DATA;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = awsize_of(wstrb_q);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b0;
    assign awcache = 4'b0;
    assign awprot  = 3'b0;

    assign wid   = ID_DATA;
    assign wdata = wdata_q;
    assign wstrb = wstrb_q;
    assign wlast = 1'b1;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed self-checking bench for sram_axi_bridge; the bench plays the AXI slave.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic        inst_ok;
    logic [31:0] inst_rdata;
    logic        data_ren;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_read_ok;
    logic        data_write_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_chk  = 0;
    int n_pass = 0;
    int cnt_inst = 0;
    int cnt_drd  = 0;
    int cnt_dwr  = 0;
    int base_inst, base_drd, base_dwr;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_ok(inst_ok), .inst_rdata(inst_rdata),
        .data_ren(data_ren), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_read_ok(data_read_ok), .data_write_ok(data_write_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            cnt_inst += int'(inst_ok);
            cnt_drd  += int'(data_read_ok);
            cnt_dwr  += int'(data_write_ok);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read with an immediately ready slave: request, AR, R, DONE, back to IDLE.
    task automatic read_txn(input string tag, input bit is_inst,
                            input logic [31:0] a, input logic [31:0] d);
        if (is_inst) begin inst_ren = 1'b1; inst_addr = a; end
        else         begin data_ren = 1'b1; data_addr = a; end
        arready = 1'b1;
        tick();
        inst_ren = 1'b0;
        data_ren = 1'b0;
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd1);
        chk({tag, "_arid"}, 32'(arid), is_inst ? 32'd0 : 32'd1);
        chk({tag, "_araddr"}, araddr, a);
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = d;
        tick();
        rvalid = 1'b0;
        chk({tag, "_ok"}, is_inst ? 32'(inst_ok) : 32'(data_read_ok), 32'd1);
        chk({tag, "_other_ok"}, is_inst ? 32'(data_read_ok) : 32'(inst_ok), 32'd0);
        chk({tag, "_rdata"}, is_inst ? inst_rdata : data_rdata, d);
        tick();
        chk({tag, "_ok_drop"}, 32'({inst_ok, data_read_ok, data_write_ok}), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        inst_ren = 1'b0; inst_addr = '0;
        data_ren = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rid = 4'hf; rdata = '0; rresp = 2'b10; rlast = 1'b1; rvalid = 1'b0;
        bid = 4'hf; bresp = 2'b10; bvalid = 1'b0;
        repeat (2) tick();

        chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk("rst_oks", 32'({inst_ok, data_read_ok, data_write_ok}), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_addr", araddr, 32'd0);
        chk("rst_wstrb", 32'(wstrb), 32'd0);
        rst = 1'b1;
        tick();

        // Instruction fetch with an eager slave: ok exactly three cycles after the request.
        inst_addr = 32'h1fc00000;
        inst_ren  = 1'b1;
        arready   = 1'b1;
        tick();
        inst_ren = 1'b0;
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_arid", 32'(arid), 32'd0);
        chk("t1_arsize", 32'(arsize), 32'd2);
        chk("t1_arlen", 32'(arlen), 32'd0);
        chk("t1_arburst", 32'(arburst), 32'd1);
        chk("t1_araddr", araddr, 32'h1fc00000);
        tick();
        arready = 1'b0;
        chk("t1_rready", 32'(rready), 32'd1);
        chk("t1_arvalid_drop", 32'(arvalid), 32'd0);
        rvalid = 1'b1;
        rdata  = 32'h3c1d0001;
        tick();
        rvalid = 1'b0;
        chk("t1_inst_ok", 32'(inst_ok), 32'd1);
        chk("t1_inst_rdata", inst_rdata, 32'h3c1d0001);
        tick();
        chk("t1_inst_ok_drop", 32'(inst_ok), 32'd0);
        chk("t1_rdata_held", inst_rdata, 32'h3c1d0001);

        // Data read with a stalled arready plus a stray inst_ren mid-transfer.
        base_inst = cnt_inst; base_drd = cnt_drd;
        data_addr = 32'h1faf0000;
        data_ren  = 1'b1;
        tick();
        data_ren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_arvalid_hold", 32'(arvalid), 32'd1);
            chk("t2_araddr_hold", araddr, 32'h1faf0000);
            inst_ren  = (i == 1);
            inst_addr = 32'h0badf00d;
            tick();
        end
        inst_ren = 1'b0;
        chk("t2_arid", 32'(arid), 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h12345678;
        tick();
        rvalid = 1'b0;
        chk("t2_data_read_ok", 32'(data_read_ok), 32'd1);
        chk("t2_data_rdata", data_rdata, 32'h12345678);
        tick();
        chk("t2_drd_count", 32'(cnt_drd - base_drd), 32'd1);
        chk("t2_inst_count", 32'(cnt_inst - base_inst), 32'd0);
        chk("t2_idle_arvalid", 32'(arvalid), 32'd0);

        // Half-word write, W accepted before AW, wen held through DONE.
        base_dwr = cnt_dwr;
        data_addr  = 32'h1faf0010;
        data_wdata = 32'hdead0000;
        data_wen   = 4'b1100;
        tick();
        chk("t3_awvalid", 32'(awvalid), 32'd1);
        chk("t3_wvalid", 32'(wvalid), 32'd1);
        chk("t3_awsize", 32'(awsize), 32'd1);
        chk("t3_wstrb", 32'(wstrb), 32'hc);
        chk("t3_wdata", wdata, 32'hdead0000);
        chk("t3_awaddr", awaddr, 32'h1faf0010);
        chk("t3_ids", 32'({awid, wid}), 32'h11);
        chk("t3_wlast", 32'(wlast), 32'd1);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("t3_wvalid_drop", 32'(wvalid), 32'd0);
        chk("t3_awvalid_hold", 32'(awvalid), 32'd1);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t3_awvalid_drop", 32'(awvalid), 32'd0);
        chk("t3_bready", 32'(bready), 32'd1);
        tick();
        chk("t3_no_early_ok", 32'(data_write_ok), 32'd0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("t3_write_ok", 32'(data_write_ok), 32'd1);
        tick();
        data_wen = 4'b0000;
        chk("t3_write_ok_drop", 32'(data_write_ok), 32'd0);
        chk("t3_no_second_aw", 32'(awvalid), 32'd0);
        tick();
        chk("t3_still_idle", 32'({awvalid, wvalid, arvalid}), 32'd0);
        chk("t3_dwr_count", 32'(cnt_dwr - base_dwr), 32'd1);

        // Simultaneous full-word write and inst_ren: write wins, inst_ren is lost.
        base_inst = cnt_inst;
        data_addr  = 32'h00000100;
        data_wdata = 32'hcafef00d;
        data_wen   = 4'b1111;
        inst_addr  = 32'h00000200;
        inst_ren   = 1'b1;
        tick();
        inst_ren = 1'b0;
        chk("t4_awvalid", 32'(awvalid), 32'd1);
        chk("t4_awsize", 32'(awsize), 32'd2);
        chk("t4_awaddr", awaddr, 32'h00000100);
        chk("t4_no_ar", 32'(arvalid), 32'd0);
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        chk("t4_bready", 32'(bready), 32'd1);
        chk("t4_valids_drop", 32'({awvalid, wvalid}), 32'd0);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("t4_write_ok", 32'(data_write_ok), 32'd1);
        tick();
        data_wen = 4'b0000;
        chk("t4_inst_dropped", 32'(arvalid), 32'd0);
        chk("t4_inst_count", 32'(cnt_inst - base_inst), 32'd0);
        read_txn("t4_fetch", 1'b1, 32'h00000200, 32'ha5a5a5a5);

        // Asynchronous reset while R is waiting on a pending rvalid.
        inst_addr = 32'h1fc00100;
        inst_ren  = 1'b1;
        arready   = 1'b1;
        tick();
        inst_ren = 1'b0;
        tick();
        arready = 1'b0;
        chk("t5_in_r", 32'(rready), 32'd1);
        rvalid = 1'b1;
        rdata  = 32'hffff0000;
        #1 rst = 1'b0;
        #1;
        chk("t5_async_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk("t5_async_rdata", inst_rdata, 32'd0);
        tick();
        chk("t5_rst_oks", 32'({inst_ok, data_read_ok, data_write_ok}), 32'd0);
        chk("t5_rst_rready", 32'(rready), 32'd0);
        rvalid = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_idle_after", 32'(arvalid), 32'd0);
        read_txn("t5_fresh", 1'b1, 32'h1fc00200, 32'h00000077);

        // Back-to-back data then instruction read.
        read_txn("t6_data", 1'b0, 32'h1faf0020, 32'h11112222);
        read_txn("t6_inst", 1'b1, 32'h1fc00010, 32'h33334444);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Single-outstanding AXI master between the CPU-side SRAM request serializer and the SoC AXI crossbar.
- Accepts one instruction read, data read or data write at a time and issues a single-beat AXI transaction for it.
- Returns a one-cycle ok pulse with registered read data.
- Owns all AXI handshaking, so the serializer above sees only pulse/level SRAM-like signals.

Parameters:
- ID_INST, 4'd0, arid used for instruction fetches.
- ID_DATA, 4'd1, arid/awid used for data accesses.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- inst_ren  in  1  one-cycle instruction read request pulse
- inst_addr  in  32  physical instruction address
- inst_ok  out  1  one-cycle pulse, inst_rdata valid
- inst_rdata  out  32  fetched word, held until next inst_ok
- data_ren  in  1  one-cycle data read request pulse
- data_wen  in  4  byte write enables, held nonzero until data_write_ok
- data_addr  in  32  physical data address
- data_wdata  in  32  write data
- data_read_ok  out  1  one-cycle pulse, data_rdata valid
- data_write_ok  out  1  one-cycle pulse, write response received
- data_rdata  out  32  loaded word, held until next data_read_ok
- arid/araddr/arvalid  out  4/32/1  read address channel
- arready  in  1  read address channel ready
- arlen/arsize  out  8/3  arlen=0, arsize=2
- arburst/arlock/arcache/arprot  out  2/2/4/3  tied 2'b01/0/0/0
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  read data channel
- rready  out  1  read data channel ready
- awid/awaddr/awvalid  out  4/32/1  write address channel
- awready  in  1  write address channel ready
- awlen/awsize  out  8/3  awlen=0, awsize derived from data_wen
- awburst/awlock/awcache/awprot  out  tied as ar*
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  write data channel
- wready  in  1  write data channel ready
- bid/bresp/bvalid  in  4/2/1  write response channel
- bready  out  1  write response channel ready

Behaviour:
Reset:
- Asynchronous on rst low.
- State IDLE; all valid/ready/ok outputs 0; rdata regs 0; captured addr/wdata/wstrb 0.

States: IDLE, AR, R, AW_W, B, DONE.

IDLE:
- Samples requests with priority data_wen!=0 > data_ren > inst_ren.
- Captures addr, wdata, wstrb, kind (INST_RD/DATA_RD/DATA_WR) into registers.
- Read: next AR, arvalid=1 next cycle, arid per kind.
- Write: next AW_W, awvalid=wvalid=1 next cycle.

AR:
- Holds arvalid and araddr stable until arready.
- Goes to R on handshake; rready=1 in R.

R:
- On rvalid&rready, rdata is written to inst_rdata or data_rdata per kind; next DONE.

AW_W:
- awvalid and wvalid are independent; aw_done/w_done flags drop each valid after its handshake.
- Same-cycle handshakes are allowed.
- Goes to B when both are done; wlast=1; wid=awid=ID_DATA.

B:
- bready=1; on bvalid goes to DONE.

DONE, one cycle:
- Exactly one of inst_ok / data_read_ok / data_write_ok is asserted (registered, driven from state+kind).
- Requests are ignored; next IDLE.
- DONE exists so data_wen, still high during the ok cycle, is not re-accepted.

Latency:
- Read with arready/rvalid asserted immediately: request cycle N, arvalid N+1, rvalid N+2, ok N+3.

awsize:
- wen 0001/0010/0100/1000 -> 0.
- 0011/1100 -> 1.
- Otherwise 2.

awaddr / araddr:
- Driven with the captured address unmodified.

Ignored inputs:
- rid, bid, rresp, bresp ignored; rlast is not checked (single beat).

Protocol rules:
- A request pulse arriving outside IDLE is a protocol error: dropped, no effect on the in-flight transaction.
- Reset mid-transaction aborts immediately; valids drop asynchronously.

Decomposition:
- Shared defines: state encodings, kind encodings (INST_RD/DATA_RD/DATA_WR), AXI constant values (burst INCR, size WORD), ID_INST/ID_DATA defaults.
- Single module; the awsize decode is a small function, no sub-module needed.

Test Plan:
- inst_ren pulse, addr 0x1fc00000, arready=1 and rvalid with rdata 0x3c1d0001 one cycle later -> arid=0, arsize=2; inst_ok pulse 3 cycles after request with inst_rdata=0x3c1d0001.
- data_ren, addr 0x1faf0000, arready low 4 cycles -> arvalid and araddr stable throughout; data_read_ok once; inst_ok never.
- data_wen=4'b1100 held, wdata 0xdead0000, wready before awready -> wvalid drops after its handshake, awsize=1, wstrb=1100; data_write_ok once after bvalid; no second AW while wen is still high in the DONE cycle.
- data_wen=1111 and inst_ren in the same cycle -> the write is served first and inst_ren is dropped (protocol error); a subsequent inst_ren in IDLE is served normally.
- rst low while in R with rvalid pending -> next cycle all outputs 0 and state IDLE; a fresh inst_ren after rst release completes normally.
- Back-to-back data_ren then inst_ren (interface sequence) -> two AR transactions, ids 1 then 0, each ok pulse exactly one cycle.
